// File: rtl/movegen_sequencer.sv
// ---------------------------------------------------------------------------
// movegen_sequencer
//
// Sequences one move-generation run on the 8x8 transceiver array. For each
// request it:
//   1. clears stale in-flight moves in the array,
//   2. streams the 64 piece codes from board RAM into the array,
//   3. waits while rays and knight hops propagate,
//   4. scans every square's 16-bit direction-hit mask and emits one move per
//      set bit on a valid/ready stream.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             run request, accepted only while idle
//   engine_color      side to move, latched on start acceptance
//   busy / done       run in progress / one-cycle end-of-run pulse
//   board_rd_addr/_data   board RAM read port (1-cycle read latency)
//   array_wr_en/_addr/_data   piece-register load into the array
//   array_color       latched side to move, broadcast to all cells
//   array_clear       forces all array move inputs to empty
//   hit_rd_addr/_data square select / combinational direction-hit mask
//   move_valid/_ready/_to/_dir   move stream to the search engine
//   move_count        moves emitted in the current (or last) run
// ---------------------------------------------------------------------------
module movegen_sequencer #(
  parameter int SETTLE_CYCLES = 8,
  parameter int CLEAR_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        engine_color,
  output logic        busy,
  output logic        done,
  output logic [5:0]  board_rd_addr,
  input  logic [5:0]  board_rd_data,
  output logic        array_wr_en,
  output logic [5:0]  array_wr_addr,
  output logic [5:0]  array_wr_data,
  output logic        array_color,
  output logic        array_clear,
  output logic [5:0]  hit_rd_addr,
  input  logic [15:0] hit_rd_data,
  output logic        move_valid,
  input  logic        move_ready,
  output logic [5:0]  move_to,
  output logic [3:0]  move_dir,
  output logic [9:0]  move_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SETTLE,
    S_SCAN,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [15:0] CLEAR_LAST  = 16'(CLEAR_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  // LOAD runs one cycle longer than the 64 reads to absorb the RAM latency.
  localparam logic [15:0] LOAD_LAST   = 16'd64;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  sq_q, sq_d;
  logic [15:0] mask_q, mask_d;
  logic [9:0]  count_q, count_d;
  logic        color_q, color_d;

  logic [3:0]  low_idx;
  logic [15:0] mask_clr;

  // Lowest set bit of the registered mask; scanning downward lets the
  // lowest index win.
  always_comb begin
    low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mask_q[i]) begin
        low_idx = 4'(i);
      end
    end
  end

  // Mask with its lowest set bit removed.
  assign mask_clr = mask_q & (mask_q - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sq_q    <= '0;
      mask_q  <= '0;
      count_q <= '0;
      color_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      color_q <= color_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sq_d          = sq_q;
    mask_d        = mask_q;
    count_d       = count_q;
    color_d       = color_q;

    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    board_rd_addr = '0;
    array_wr_en   = 1'b0;
    array_wr_addr = '0;
    array_wr_data = '0;
    array_clear   = 1'b0;
    hit_rd_addr   = '0;
    move_valid    = 1'b0;
    move_to       = '0;
    move_dir      = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          color_d = engine_color;
          count_d = '0;
          cnt_d   = '0;
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        array_clear = 1'b1;
        if (cnt_q == CLEAR_LAST) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_LOAD: begin
        if (cnt_q < LOAD_LAST) begin
          board_rd_addr = cnt_q[5:0];
        end
        // Data for the address issued last cycle is on board_rd_data now.
        if (cnt_q != 16'd0) begin
          array_wr_en   = 1'b1;
          array_wr_addr = 6'(cnt_q - 16'd1);
          array_wr_data = board_rd_data;
        end
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          sq_d    = '0;
          state_d = S_SCAN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_SCAN: begin
        hit_rd_addr = sq_q;
        if (hit_rd_data != 16'd0) begin
          mask_d  = hit_rd_data;
          state_d = S_EMIT;
        end else if (sq_q == 6'd63) begin
          state_d = S_DONE;
        end else begin
          sq_d = sq_q + 6'd1;
        end
      end

      S_EMIT: begin
        move_valid = 1'b1;
        move_to    = sq_q;
        move_dir   = low_idx;
        if (move_ready) begin
          mask_d  = mask_clr;
          count_d = count_q + 10'd1;
          if (mask_clr == 16'd0) begin
            if (sq_q == 6'd63) begin
              state_d = S_DONE;
            end else begin
              sq_d    = sq_q + 6'd1;
              state_d = S_SCAN;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign array_color = color_q;
  assign move_count  = count_q;

endmodule
